user_ip_gpio_ctrl: RTL and testbench
====================================

# user_ip_gpio_ctrl

- Parametrised APB4-slave user IP for the user-design slot of the mini SoC; the next generation of the fixed-function user IP stub.
- Exposes an ID/capability register, per-pin output and output-enable registers, atomic set/clear, a synchronised input view, and edge-triggered interrupts with write-1-to-clear status.
- Drives the `user_gpio_if` pins and a level interrupt toward the SoC interrupt controller.

## Interface
- `ID`, 8'hFF: user IP identifier, reported in ID[7:0].
- `GPIO_WIDTH`, 16: number of pins, legal range 1..32; register bits above `GPIO_WIDTH` read 0 and ignore writes.
- `SYNC_STAGES`, 2: input synchroniser depth, legal range 2..4.
- `clk_i` input 1: single clock for all logic.
- `rst_i` input 1: synchronous reset, active-high.
- `gpio` `user_gpio_if.dut`, `GPIO_WIDTH`: `gpio_in` sampled, `gpio_out`/`gpio_oen` driven; `gpio_oen` is active-low, so 0 means the pin is driven.
- `apb` `apb4_if.slave`, 32-bit data: `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `pstrb`, `prdata`, `pready`, `pslverr`.
- `irq_o` output 1: level interrupt, high while any enabled status bit is set.

## Operation
- Write handshake: `psel & penable & pwrite`. Read handshake: `psel & penable & ~pwrite`.
- `pready` is tied 1, so every access completes with zero wait states.
- Decode uses `paddr[7:0]`. `pstrb` is ignored; writes are always full-word.
- Register map (offsets live in the package):
  - 0x00 ID, RO: {16'd0, GPIO_WIDTH[7:0], ID}.
  - 0x04 OUT, RW, reset 0: drives `gpio_out`.
  - 0x08 OEN, RW, reset all-ones: drives `gpio_oen`; all pins are inputs after reset.
  - 0x0C IN, RO: synchronised `gpio_in`.
  - 0x10 SET, WO (reads 0): OUT |= pwdata.
  - 0x14 CLR, WO (reads 0): OUT &= ~pwdata.
  - 0x18 RISE_EN, RW, reset 0.
  - 0x1C FALL_EN, RW, reset 0.
  - 0x20 STAT, RW1C, reset 0: sticky edge-event bits.
  - 0x24 IRQ_EN, RW, reset 0.
- Edge detection works on the synchronised value `s` and its one-cycle delay `d`:
  - rise = s & ~d & RISE_EN.
  - fall = ~s & d & FALL_EN.
  - Each detected edge sets the corresponding STAT bit.
- Writing 1 to a STAT bit clears it. If an edge and a W1C hit the same bit in the same cycle, the set wins and the bit stays 1.
- irq_o = |(STAT & IRQ_EN), registered.
- Access to an unmapped offset (0x28..0xFC): `pslverr` = 1 during the access phase, `prdata` = 0, no state change.
- Writes to RO offsets are ignored with `pslverr` = 0.
- `prdata` is 0 whenever there is no read handshake.
- Reset values:
  - Registers as listed in the map.
  - Synchroniser and delay flops cleared to 0.
  - `irq_o` = 0, `pslverr` = 0, `prdata` = 0.
  - Because the flops clear to 0, a pin held high through reset produces a rise event only if RISE_EN is already set when the synchronised 1 arrives.
- Reset asserted mid-transfer aborts the transfer. The next cycle shows reset values regardless of the APB handshake.

## Timing
- `prdata` and `pslverr` are combinational from the address in the access phase.
- A write takes effect at the clock edge ending the access phase:
  - `gpio_out` and `gpio_oen` change in the next cycle.
  - SET and CLR behave the same way as OUT writes.
- Pin change on `gpio_in`:
  - Visible in IN after `SYNC_STAGES` cycles.
  - STAT bit set after `SYNC_STAGES`+1 cycles.
  - `irq_o` asserts after `SYNC_STAGES`+2 cycles.
- W1C of the last enabled STAT bit: `irq_o` deasserts 2 cycles after the handshake edge (STAT clears, then the registered irq follows).
- Back-to-back accesses are legal: each access is 2 cycles (setup plus access), with no idle cycle required between them.

## Structure
- Package `user_ip_gpio_pkg` holds:
  - the register offset localparams;
  - a `gpio_reg_t` struct {out, oen, rise_en, fall_en, irq_en, stat}, each 32 bits;
  - the `GPIO_MAX_WIDTH` = 32 constant.
- Sub-module `user_ip_gpio_sync` (parameters WIDTH, STAGES) contains the synchroniser chain plus the delay flop. It outputs `s`, `rise_raw` and `fall_raw`.
- The top level contains the APB decode, register file, STAT update, and the irq register.

## Test plan
- Reset then read 0x00 with ID=8'h5A, GPIO_WIDTH=16: expect 0x0000_105A. OEN reads 0x0000_FFFF and OUT reads 0.
- Write OUT=0xA5A5, SET=0x000F, CLR=0x0080: OUT reads 0xA52F. `gpio_out` equals 0xA52F one cycle after the last write. Writing 0xFFFF_FFFF to OUT reads back 0x0000_FFFF.
- RISE_EN=1, IRQ_EN=1, drive `gpio_in[0]` 0→1: STAT[0]=1 after 3 cycles and `irq_o`=1 after 4. A FALL on bit 0 with FALL_EN=0 leaves STAT unchanged.
- W1C STAT=0x1 in the same cycle as a new rise on bit 0: STAT[0] stays 1 and `irq_o` stays 1. A later W1C with no edge clears it, and `irq_o` falls 2 cycles after.
- Read or write offset 0x40: `pslverr`=1, `prdata`=0, no register changes. A write to 0x0C gives `pslverr`=0 and IN is unaffected.
- Assert `rst_i` during the access phase of an OUT write of 0x1234: OUT reads 0 after reset and `irq_o`=0.

Source files
------------

// File: rtl/user_ip_gpio_pkg.sv
// user_ip_gpio_pkg
// Shared definitions for the GPIO user IP: register offsets on the low
// address byte, the register-file struct, and the widest pin count.
package user_ip_gpio_pkg;

  localparam int GPIO_MAX_WIDTH = 32;

  localparam logic [7:0] OFF_ID      = 8'h00;
  localparam logic [7:0] OFF_OUT     = 8'h04;
  localparam logic [7:0] OFF_OEN     = 8'h08;
  localparam logic [7:0] OFF_IN      = 8'h0C;
  localparam logic [7:0] OFF_SET     = 8'h10;
  localparam logic [7:0] OFF_CLR     = 8'h14;
  localparam logic [7:0] OFF_RISE_EN = 8'h18;
  localparam logic [7:0] OFF_FALL_EN = 8'h1C;
  localparam logic [7:0] OFF_STAT    = 8'h20;
  localparam logic [7:0] OFF_IRQ_EN  = 8'h24;

  typedef struct packed {
    logic [31:0] out;
    logic [31:0] oen;
    logic [31:0] rise_en;
    logic [31:0] fall_en;
    logic [31:0] irq_en;
    logic [31:0] stat;
  } gpio_reg_t;

  // Word-aligned offsets 0x00..0x24 are decoded; everything else errors.
  function automatic logic is_mapped(input logic [7:0] off);
    return (off[1:0] == 2'b00) && (off <= OFF_IRQ_EN);
  endfunction

endpackage

// File: rtl/user_ip_gpio_sync.sv
// user_ip_gpio_sync
// Multi-stage input synchroniser followed by one delay flop, giving the
// synchronised pin view and raw (unmasked) edge strobes.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (all flops clear to 0)
//   pins           asynchronous pin inputs
//   s              synchronised pin value
//   rise_raw       s & ~d  (d = s delayed one cycle)
//   fall_raw       ~s & d
module user_ip_gpio_sync #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] rise_raw,
  output logic [WIDTH-1:0] fall_raw
);

  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      d <= '0;
    end else begin
      chain[0] <= pins;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      d <= chain[STAGES-1];
    end
  end

  assign s        = chain[STAGES-1];
  assign rise_raw = s & ~d;
  assign fall_raw = ~s & d;

endmodule

// File: rtl/user_ip_gpio_ctrl.sv
// user_ip_gpio_ctrl
// APB4 slave GPIO block: ID, output/output-enable registers with atomic
// set/clear, synchronised input view, edge interrupts with W1C status.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   psel .. pstrb         APB4 request (pstrb ignored, writes are full-word)
//   prdata, pready,       APB4 response; pready is constant 1
//   pslverr
//   gpio_in               asynchronous pin inputs
//   gpio_out, gpio_oen    pin drive value and active-low output enable
//   irq_o                 registered level interrupt
//
// Handshake: an access completes on the clock edge where psel & penable is
// high (pready is always 1, so no wait states). pwrite selects write/read.
// prdata/pslverr are combinational in that access phase and 0 otherwise.
module user_ip_gpio_ctrl
  import user_ip_gpio_pkg::*;
#(
  parameter logic [7:0] ID          = 8'hFF,
  parameter int         GPIO_WIDTH  = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [31:0]           paddr,
  input  logic [31:0]           pwdata,
  input  logic [3:0]            pstrb,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oen,
  output logic                  irq_o
);

  // Bits above GPIO_WIDTH never hold state and always read 0.
  localparam logic [31:0] PIN_MASK = 32'((64'd1 << GPIO_WIDTH) - 64'd1);
  localparam logic [31:0] ID_WORD  = {16'd0, 8'(GPIO_WIDTH), ID};

  gpio_reg_t regs;

  logic [7:0]            off;
  logic                  access;
  logic                  wr_hs;
  logic                  rd_hs;
  logic [31:0]           wdata;
  logic [31:0]           w1c;
  logic [31:0]           edge_evt;
  logic [GPIO_WIDTH-1:0] s;
  logic [GPIO_WIDTH-1:0] rise_raw;
  logic [GPIO_WIDTH-1:0] fall_raw;
  logic                  unused_bits;

  assign unused_bits = &{1'b0, paddr[31:8], pstrb};

  assign off    = paddr[7:0];
  assign access = psel & penable;
  assign wr_hs  = access & pwrite;
  assign rd_hs  = access & ~pwrite;
  assign wdata  = pwdata & PIN_MASK;

  user_ip_gpio_sync #(
    .WIDTH  (GPIO_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .pins     (gpio_in),
    .s        (s),
    .rise_raw (rise_raw),
    .fall_raw (fall_raw)
  );

  assign edge_evt = (32'(rise_raw) & regs.rise_en) | (32'(fall_raw) & regs.fall_en);
  assign w1c      = (wr_hs && off == OFF_STAT) ? wdata : '0;

  always_comb begin
    prdata = '0;
    if (rd_hs && !rst_i) begin
      case (off)
        OFF_ID:      prdata = ID_WORD;
        OFF_OUT:     prdata = regs.out;
        OFF_OEN:     prdata = regs.oen;
        OFF_IN:      prdata = 32'(s);
        OFF_RISE_EN: prdata = regs.rise_en;
        OFF_FALL_EN: prdata = regs.fall_en;
        OFF_STAT:    prdata = regs.stat;
        OFF_IRQ_EN:  prdata = regs.irq_en;
        default:     prdata = '0;
      endcase
    end
  end

  assign pslverr = access & ~is_mapped(off) & ~rst_i;
  assign pready  = 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs.out     <= '0;
      regs.oen     <= PIN_MASK;
      regs.rise_en <= '0;
      regs.fall_en <= '0;
      regs.irq_en  <= '0;
      regs.stat    <= '0;
      irq_o        <= 1'b0;
    end else begin
      if (wr_hs) begin
        case (off)
          OFF_OUT:     regs.out     <= wdata;
          OFF_OEN:     regs.oen     <= wdata;
          OFF_SET:     regs.out     <= regs.out | wdata;
          OFF_CLR:     regs.out     <= regs.out & ~wdata;
          OFF_RISE_EN: regs.rise_en <= wdata;
          OFF_FALL_EN: regs.fall_en <= wdata;
          OFF_IRQ_EN:  regs.irq_en  <= wdata;
          default:     ;
        endcase
      end
      // New edges are OR-ed in after the W1C so a same-cycle event wins.
      regs.stat <= (regs.stat & ~w1c) | edge_evt;
      irq_o     <= |(regs.stat & regs.irq_en);
    end
  end

  assign gpio_out = regs.out[GPIO_WIDTH-1:0];
  assign gpio_oen = regs.oen[GPIO_WIDTH-1:0];

endmodule

// File: tb/tb_user_ip_gpio_ctrl.sv
module tb_user_ip_gpio_ctrl;

  localparam int W      = 16;
  localparam int STAGES = 2;

  logic          clk;
  logic          rst_i;
  logic          psel, penable, pwrite;
  logic [31:0]   paddr, pwdata;
  logic [3:0]    pstrb;
  logic [31:0]   prdata;
  logic          pready, pslverr;
  logic [W-1:0]  gpio_in, gpio_out, gpio_oen;
  logic          irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  user_ip_gpio_ctrl #(
    .ID          (8'h5A),
    .GPIO_WIDTH  (W),
    .SYNC_STAGES (STAGES)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pstrb    (pstrb),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oen (gpio_oen),
    .irq_o    (irq_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_out, m_oen, m_rise, m_fall, m_irqen, m_stat;
  logic [W-1:0] m_s, m_d;
  logic [W-1:0] m_hist[$];
  logic        m_irq;
  logic        model_valid = 1'b0;

  function automatic logic mapped(input logic [7:0] a);
    return (a[1:0] == 2'b00) && (a <= 8'h24);
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      8'h00:   return 32'h0000_105A;
      8'h04:   return m_out;
      8'h08:   return m_oen;
      8'h0C:   return 32'(m_s);
      8'h18:   return m_rise;
      8'h1C:   return m_fall;
      8'h20:   return m_stat;
      8'h24:   return m_irqen;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] ev;
    logic [31:0]  wd, clr;
    if (rst_i) begin
      m_out = 0; m_oen = 32'h0000_FFFF; m_rise = 0; m_fall = 0;
      m_irqen = 0; m_stat = 0; m_irq = 0; m_s = 0; m_d = 0;
      m_hist = {};
      for (int i = 0; i < STAGES; i++) m_hist.push_back('0);
      model_valid = 1'b1;
    end else if (model_valid) begin
      ev    = (m_s & ~m_d & m_rise[W-1:0]) | (~m_s & m_d & m_fall[W-1:0]);
      m_irq = |(m_stat & m_irqen);
      clr   = 0;
      if (psel && penable && pwrite) begin
        wd = pwdata & 32'h0000_FFFF;
        case (paddr[7:0])
          8'h04: m_out   = wd;
          8'h08: m_oen   = wd;
          8'h10: m_out   = m_out | wd;
          8'h14: m_out   = m_out & ~wd;
          8'h18: m_rise  = wd;
          8'h1C: m_fall  = wd;
          8'h20: clr     = wd;
          8'h24: m_irqen = wd;
          default: ;
        endcase
      end
      m_stat = (m_stat & ~clr) | 32'(ev);
      m_d = m_s;
      m_hist.push_back(gpio_in);
      void'(m_hist.pop_front());
      m_s = m_hist[0];
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid && !rst_i) begin
      check("gpio_out", 32'(gpio_out), m_out);
      check("gpio_oen", 32'(gpio_oen), m_oen);
      check("irq_o", 32'(irq_o), 32'(m_irq));
      check("pready", 32'(pready), 32'h1);
      if (!(psel && penable && !pwrite)) check("prdata_idle", prdata, 32'h0);
      if (!(psel && penable)) check("pslverr_idle", 32'(pslverr), 32'h0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    logic exp_err;
    psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = {24'($urandom), a}; pwdata = d; pstrb = 4'($urandom);
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    exp_err = !mapped(a);
    exp_q.push_back((wr || exp_err) ? 32'h0 : model_read(a));
    rd  = prdata;
    err = pslverr;
    check("apb_pslverr", 32'(pslverr), 32'(exp_err));
    check("apb_prdata", prdata, exp_q.pop_front());
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  logic [7:0] offs [14] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18,
                            8'h1C, 8'h20, 8'h24, 8'h28, 8'h40, 8'hFC, 8'h20};

  initial begin
    logic [31:0] rd;
    logic        err;
    rst_i = 1'b1; psel = 0; penable = 0; pwrite = 0;
    paddr = 0; pwdata = 0; pstrb = 0; gpio_in = '0;
    cycles(3);
    rst_i = 1'b0;
    cycles(1);

    // reset state
    apb(0, 8'h00, 0, rd, err); check("id_word", rd, 32'h0000_105A);
    apb(0, 8'h08, 0, rd, err); check("oen_reset", rd, 32'h0000_FFFF);
    apb(0, 8'h04, 0, rd, err); check("out_reset", rd, 32'h0);
    check("irq_reset", 32'(irq_o), 32'h0);

    // OUT / SET / CLR
    apb(1, 8'h04, 32'h0000_A5A5, rd, err);
    apb(1, 8'h10, 32'h0000_000F, rd, err);
    apb(1, 8'h14, 32'h0000_0080, rd, err);
    check("gpio_out_after_clr", 32'(gpio_out), 32'h0000_A52F);
    apb(0, 8'h04, 0, rd, err); check("out_set_clr", rd, 32'h0000_A52F);
    apb(0, 8'h10, 0, rd, err); check("set_reads_0", rd, 32'h0);
    apb(1, 8'h04, 32'hFFFF_FFFF, rd, err);
    apb(0, 8'h04, 0, rd, err); check("out_masked", rd, 32'h0000_FFFF);

    // rise on bit 0 with RISE_EN and IRQ_EN set
    apb(1, 8'h18, 32'h1, rd, err);
    apb(1, 8'h24, 32'h1, rd, err);
    gpio_in[0] = 1'b1;
    cycles(2);
    check("irq_before_stat", 32'(irq_o), 32'h0);
    apb(0, 8'h20, 0, rd, err); check("stat_rise_3cyc", rd, 32'h1);
    check("irq_4cyc", 32'(irq_o), 32'h1);

    // fall with FALL_EN=0 leaves STAT alone
    gpio_in[0] = 1'b0;
    cycles(6);
    apb(0, 8'h20, 0, rd, err); check("stat_after_fall", rd, 32'h1);

    // W1C colliding with a new rise: set wins
    gpio_in[0] = 1'b1;
    cycles(1);
    apb(1, 8'h20, 32'h1, rd, err);
    apb(0, 8'h20, 0, rd, err); check("stat_set_wins", rd, 32'h1);
    check("irq_held", 32'(irq_o), 32'h1);
    apb(1, 8'h20, 32'h1, rd, err);
    check("irq_after_w1c_1", 32'(irq_o), 32'h1);
    cycles(1);
    check("irq_after_w1c_2", 32'(irq_o), 32'h0);
    apb(0, 8'h20, 0, rd, err); check("stat_cleared", rd, 32'h0);

    // unmapped and read-only offsets
    apb(0, 8'h40, 0, rd, err);
    check("unmapped_rd_err", 32'(err), 32'h1);
    check("unmapped_rd_data", rd, 32'h0);
    apb(1, 8'h40, 32'hFFFF_FFFF, rd, err);
    check("unmapped_wr_err", 32'(err), 32'h1);
    apb(0, 8'h04, 0, rd, err); check("out_untouched", rd, 32'h0000_FFFF);
    apb(1, 8'h0C, 32'h0000_FFFF, rd, err);
    check("ro_wr_err", 32'(err), 32'h0);
    apb(0, 8'h0C, 0, rd, err); check("in_view", rd, 32'h0000_0001);

    // raise irq, then reset in the access phase of an OUT write
    gpio_in[0] = 1'b0; cycles(4);
    gpio_in[0] = 1'b1; cycles(5);
    check("irq_before_reset", 32'(irq_o), 32'h1);
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h04; pwdata = 32'h1234;
    cycles(1);
    penable = 1; rst_i = 1'b1;
    cycles(1);
    rst_i = 1'b0; psel = 0; penable = 0; pwrite = 0;
    check("irq_after_reset", 32'(irq_o), 32'h0);
    apb(0, 8'h04, 0, rd, err); check("out_after_reset", rd, 32'h0);
    apb(0, 8'h08, 0, rd, err); check("oen_after_reset", rd, 32'h0000_FFFF);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) gpio_in = W'($urandom);
      apb(1'($urandom_range(0, 1)), offs[$urandom_range(0, 13)], $urandom, rd, err);
      if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 4));
    end
    cycles(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
